ventana_cruz_laplace: RTL and testbench

//  Stage directly upstream of the approximate 5-point Laplace filter. Accepts an 8-bit

---
 rtl/ventana_cruz_laplace_if.sv | 34 +++
 rtl/ventana_cruz_laplace.sv | 139 +++++++++++++
 tb/tb_ventana_cruz_laplace.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/ventana_cruz_laplace_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | ventana_cruz_laplace_if : pixel-in / cross-window-out handshake bundle  |
// | Revision 1.0                                                           |
// +------------------------------------------------------------------------+
interface ventana_cruz_laplace_if;
   logic [7:0] in_pix;
   logic       in_valid;
   logic       in_sof;
   logic       in_ready;
   logic [7:0] win_b;
   logic [7:0] win_d;
   logic [7:0] win_e;
   logic [7:0] win_f;
   logic [7:0] win_h;
   logic [9:0] win_x;
   logic [9:0] win_y;
   logic       win_last;
   logic       win_valid;
   logic       win_ready;

   modport master (
      output in_pix, in_valid, in_sof, win_ready,
      input  in_ready, win_b, win_d, win_e, win_f, win_h,
             win_x, win_y, win_last, win_valid
   );

   modport slave (
      input  in_pix, in_valid, in_sof, win_ready,
      output in_ready, win_b, win_d, win_e, win_f, win_h,
             win_x, win_y, win_last, win_valid
   );
endinterface
`default_nettype wire

// File: rtl/ventana_cruz_laplace.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | ventana_cruz_laplace : raster pixels -> 5-point cross window, 1-deep out |
// | Revision 1.0                                                           |
// +------------------------------------------------------------------------+
module ventana_cruz_laplace #(
   parameter int IMG_W = 64,
   parameter int IMG_H = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   ventana_cruz_laplace_if.slave  bus_io
);
   localparam int         AW         = $clog2(IMG_W);
   localparam logic [9:0] c_LAST_COL = 10'(IMG_W - 1);
   localparam logic [9:0] c_LAST_ROW = 10'(IMG_H - 1);
   localparam logic [9:0] c_WIN_MIN  = 10'd2;

   logic [9:0]    col_q, col_d, row_q, row_d;
   logic [7:0]    top_s1_q, mid_s1_q, mid_s2_q, pix_s1_q;
   logic [7:0]    lb_top_q [IMG_W];
   logic [7:0]    lb_mid_q [IMG_W];

   logic [7:0]    win_b_q, win_b_d, win_d_q, win_d_d, win_e_q, win_e_d;
   logic [7:0]    win_f_q, win_f_d, win_h_q, win_h_d;
   logic [9:0]    win_x_q, win_x_d, win_y_q, win_y_d;
   logic          win_last_q, win_last_d, win_valid_q, win_valid_d;

   logic          w_in_ready, w_accept, w_emit;
   logic [9:0]    w_pos_col, w_pos_row;
   logic [AW-1:0] w_addr;
   logic [7:0]    w_top, w_mid;

   assign w_in_ready = ~rst & (~win_valid_q | bus_io.win_ready);
   assign w_accept   = bus_io.in_valid & w_in_ready;

   // in_sof overrides the running counters so the flagged pixel is always (0,0)
   assign w_pos_col = bus_io.in_sof ? 10'd0 : col_q;
   assign w_pos_row = bus_io.in_sof ? 10'd0 : row_q;
   assign w_addr    = w_pos_col[AW-1:0];
   assign w_top     = lb_top_q[w_addr];
   assign w_mid     = lb_mid_q[w_addr];
   assign w_emit    = w_accept && (w_pos_row >= c_WIN_MIN) && (w_pos_col >= c_WIN_MIN);

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (w_accept) begin
         if (w_pos_col == c_LAST_COL) begin
            col_d = 10'd0;
            row_d = (w_pos_row == c_LAST_ROW) ? 10'd0 : w_pos_row + 10'd1;
         end else begin
            col_d = w_pos_col + 10'd1;
            row_d = w_pos_row;
         end
      end
   end

   always_comb begin
      win_b_d     = win_b_q;
      win_d_d     = win_d_q;
      win_e_d     = win_e_q;
      win_f_d     = win_f_q;
      win_h_d     = win_h_q;
      win_x_d     = win_x_q;
      win_y_d     = win_y_q;
      win_last_d  = win_last_q;
      win_valid_d = win_valid_q & ~bus_io.win_ready;
      if (w_emit) begin
         win_b_d     = top_s1_q;
         win_d_d     = mid_s2_q;
         win_e_d     = mid_s1_q;
         win_f_d     = w_mid;
         win_h_d     = pix_s1_q;
         win_x_d     = w_pos_col - 10'd1;
         win_y_d     = w_pos_row - 10'd1;
         win_last_d  = (w_pos_row == c_LAST_ROW) && (w_pos_col == c_LAST_COL);
         win_valid_d = 1'b1;
      end
   end

   // Read-before-write: the row leaving lb_mid moves into lb_top at the same address
   always_ff @(posedge clk) begin
      if (w_accept) begin
         lb_top_q[w_addr] <= w_mid;
         lb_mid_q[w_addr] <= bus_io.in_pix;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col_q       <= '0;
         row_q       <= '0;
         top_s1_q    <= '0;
         mid_s1_q    <= '0;
         mid_s2_q    <= '0;
         pix_s1_q    <= '0;
         win_b_q     <= '0;
         win_d_q     <= '0;
         win_e_q     <= '0;
         win_f_q     <= '0;
         win_h_q     <= '0;
         win_x_q     <= '0;
         win_y_q     <= '0;
         win_last_q  <= 1'b0;
         win_valid_q <= 1'b0;
      end else begin
         col_q       <= col_d;
         row_q       <= row_d;
         if (w_accept) begin
            top_s1_q <= w_top;
            mid_s2_q <= mid_s1_q;
            mid_s1_q <= w_mid;
            pix_s1_q <= bus_io.in_pix;
         end
         win_b_q     <= win_b_d;
         win_d_q     <= win_d_d;
         win_e_q     <= win_e_d;
         win_f_q     <= win_f_d;
         win_h_q     <= win_h_d;
         win_x_q     <= win_x_d;
         win_y_q     <= win_y_d;
         win_last_q  <= win_last_d;
         win_valid_q <= win_valid_d;
      end
   end

   assign bus_io.in_ready  = w_in_ready;
   assign bus_io.win_b     = win_b_q;
   assign bus_io.win_d     = win_d_q;
   assign bus_io.win_e     = win_e_q;
   assign bus_io.win_f     = win_f_q;
   assign bus_io.win_h     = win_h_q;
   assign bus_io.win_x     = win_x_q;
   assign bus_io.win_y     = win_y_q;
   assign bus_io.win_last  = win_last_q;
   assign bus_io.win_valid = win_valid_q;
endmodule
`default_nettype wire

// File: tb/tb_ventana_cruz_laplace.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_ventana_cruz_laplace : scoreboard bench, 4x4 and 5x5 instances       |
// | Revision 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_ventana_cruz_laplace;
   typedef struct packed {
      logic [7:0] b, d, e, f, h;
      logic [9:0] x, y;
      logic       last;
   } win_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   win_t q4[$];
   win_t q5[$];

   always #5 clk = ~clk;

   ventana_cruz_laplace_if if4 ();
   ventana_cruz_laplace_if if5 ();

   ventana_cruz_laplace #(.IMG_W(4), .IMG_H(4)) u_dut4 (.clk(clk), .rst(rst), .bus_io(if4));
   ventana_cruz_laplace #(.IMG_W(5), .IMG_H(5)) u_dut5 (.clk(clk), .rst(rst), .bus_io(if5));

   function automatic win_t mkwin(input int b, input int d, input int e, input int f,
                                  input int h, input int x, input int y, input bit last);
      win_t w;
      w.b = 8'(b); w.d = 8'(d); w.e = 8'(e); w.f = 8'(f); w.h = 8'(h);
      w.x = 10'(x); w.y = 10'(y); w.last = last;
      return w;
   endfunction

   function automatic int pixv(input int kind, input int r, input int c);
      case (kind)
         0:       return 16 * r + c;
         1:       return 255 - (16 * r + c);
         2:       return 100 + 16 * r + c;
         default: return 255;
      endcase
   endfunction

   task automatic push_exp(input int sel, input win_t w);
      if (sel == 0) q4.push_back(w);
      else          q5.push_back(w);
   endtask

   // Expected cross taken straight from the pixel formula around centre (y,x)
   task automatic push_win(input int sel, input int kind, input int w, input int h,
                           input int y, input int x);
      push_exp(sel, mkwin(pixv(kind, y - 1, x), pixv(kind, y, x - 1), pixv(kind, y, x),
                          pixv(kind, y, x + 1), pixv(kind, y + 1, x), x, y,
                          (y == h - 2) && (x == w - 2)));
   endtask

   task automatic drive_in(input int sel, input logic v, input logic [7:0] p, input logic s);
      if (sel == 0) begin
         if4.in_valid = v; if4.in_pix = p; if4.in_sof = s;
      end else begin
         if5.in_valid = v; if5.in_pix = p; if5.in_sof = s;
      end
   endtask

   task automatic send_pix(input int sel, input logic [7:0] p, input logic s);
      int n = 0;
      logic ok;
      @(negedge clk);
      drive_in(sel, 1'b1, p, s);
      forever begin
         #2;
         ok = (sel == 0) ? if4.in_ready : if5.in_ready;
         @(posedge clk);
         if (ok) break;
         n++;
         if (n > 200) begin
            checks++; errors++;
            $display("FAIL in_ready_timeout: in_ready stayed %b, required 1", ok);
            break;
         end
         @(negedge clk);
      end
      #1 drive_in(sel, 1'b0, 8'd0, 1'b0);
   endtask

   task automatic send_frame(input int sel, input int kind, input int w, input int h,
                             input int npix, input bit sof_first, input bit push);
      for (int i = 0; i < npix; i++) begin
         int r = i / w;
         int c = i % w;
         if (push && r >= 2 && c >= 2) push_win(sel, kind, w, h, r - 1, c - 1);
         send_pix(sel, 8'(pixv(kind, r, c)), sof_first && (i == 0));
      end
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((q4.size() != 0 || q5.size() != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (q4.size() != 0 || q5.size() != 0) begin
         errors++;
         $display("FAIL drain_%s: pending windows %0d/%0d, required 0/0", name, q4.size(), q5.size());
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic check_reset_state(input string name);
      checks++;
      if (if4.win_valid !== 1'b0 || if4.win_last !== 1'b0 || if4.in_ready !== 1'b0 ||
          {if4.win_b, if4.win_d, if4.win_e, if4.win_f, if4.win_h} !== 40'd0 ||
          {if4.win_x, if4.win_y} !== 20'd0) begin
         errors++;
         $display("FAIL %s: valid=%b last=%b in_ready=%b b=%0d d=%0d e=%0d f=%0d h=%0d x=%0d y=%0d, required all 0",
                  name, if4.win_valid, if4.win_last, if4.in_ready, if4.win_b, if4.win_d,
                  if4.win_e, if4.win_f, if4.win_h, if4.win_x, if4.win_y);
      end
   endtask

   // Monitor: samples just before the rising edge, pops on each handshake
   task automatic mon(input int sel);
      win_t act, exp;
      logic v, r, ir;
      if (sel == 0) begin
         v = if4.win_valid; r = if4.win_ready; ir = if4.in_ready;
         act = {if4.win_b, if4.win_d, if4.win_e, if4.win_f, if4.win_h, if4.win_x, if4.win_y, if4.win_last};
      end else begin
         v = if5.win_valid; r = if5.win_ready; ir = if5.in_ready;
         act = {if5.win_b, if5.win_d, if5.win_e, if5.win_f, if5.win_h, if5.win_x, if5.win_y, if5.win_last};
      end
      if (rst || v !== 1'b1) return;
      checks++;
      if ((sel == 0) ? (q4.size() == 0) : (q5.size() == 0)) begin
         errors++;
         $display("FAIL win%0d_unexpected: got window x=%0d y=%0d e=%0d, required none", sel, act.x, act.y, act.e);
         return;
      end
      exp = (sel == 0) ? q4[0] : q5[0];
      if (act !== exp || ir !== r) begin
         errors++;
         $display("FAIL win%0d: got b=%0d d=%0d e=%0d f=%0d h=%0d x=%0d y=%0d last=%b in_ready=%b, required b=%0d d=%0d e=%0d f=%0d h=%0d x=%0d y=%0d last=%b in_ready=%b",
                  sel, act.b, act.d, act.e, act.f, act.h, act.x, act.y, act.last, ir,
                  exp.b, exp.d, exp.e, exp.f, exp.h, exp.x, exp.y, exp.last, r);
      end
      if (r) begin
         if (sel == 0) void'(q4.pop_front());
         else          void'(q5.pop_front());
      end
   endtask

   always @(negedge clk) begin #3; mon(0); end
   always @(negedge clk) begin #3; mon(1); end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, required completion");
      $fatal(1);
   end

   initial begin
      drive_in(0, 1'b0, 8'd0, 1'b0);
      drive_in(1, 1'b0, 8'd0, 1'b0);
      if4.win_ready = 1'b1;
      if5.win_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk); #3;
      check_reset_state("reset_state");
      @(negedge clk);
      rst = 1'b0;

      // Frame 1 with hand-computed windows
      push_exp(0, mkwin( 1, 16, 17, 18, 33, 1, 1, 1'b0));
      push_exp(0, mkwin( 2, 17, 18, 19, 34, 2, 1, 1'b0));
      push_exp(0, mkwin(17, 32, 33, 34, 49, 1, 2, 1'b0));
      push_exp(0, mkwin(18, 33, 34, 35, 50, 2, 2, 1'b1));
      send_frame(0, 0, 4, 4, 16, 1'b1, 1'b0);
      wait_drain("frame1");

      // Same frame, consumer stalls 5 cycles on the first window
      fork
         send_frame(0, 0, 4, 4, 16, 1'b0, 1'b1);
         begin
            int n = 0;
            do begin
               @(negedge clk); #1;
               n++;
            end while (if4.win_valid !== 1'b1 && n < 300);
            if (n >= 300) begin
               checks++; errors++;
               $display("FAIL stall_wait: win_valid=%b, required 1", if4.win_valid);
            end else begin
               if4.win_ready = 1'b0;
               repeat (5) @(negedge clk);
               #1 if4.win_ready = 1'b1;
            end
         end
      join
      wait_drain("stall");

      // Back-to-back frames, counters wrap without in_sof
      send_frame(0, 0, 4, 4, 16, 1'b0, 1'b1);
      send_frame(0, 1, 4, 4, 16, 1'b0, 1'b1);
      wait_drain("b2b");

      // in_sof at (2,3): old window (1,1) completes, new frame restarts
      send_frame(0, 0, 4, 4, 11, 1'b0, 1'b1);
      send_frame(0, 2, 4, 4, 16, 1'b1, 1'b1);
      wait_drain("sof");

      // Reset after 9 pixels, then a fresh frame without in_sof
      send_frame(0, 0, 4, 4, 9, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk); #3;
      check_reset_state("reset_midframe");
      #1 rst = 1'b0;
      send_frame(0, 1, 4, 4, 16, 1'b0, 1'b1);
      wait_drain("after_reset");

      // All-255 5x5 frame
      send_frame(1, 3, 5, 5, 25, 1'b1, 1'b1);
      wait_drain("frame5x5");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
